pc_branch_unit: RTL and testbench

Program-counter and branch-resolution stage sitting directly upstream of the ALU datapath. It latches the ALU status flags (Zero, Parity, Odd, SC_out) into a flag register. It evaluates conditional branches against those registered flags and produces the next instruction address for instruction memory. A small run-control state machine sequences program start, execution and halt/done handshaking with the test harness.

---
 rtl/pc_branch_unit_pkg.sv | 60 ++++++
 rtl/pc_branch_unit_lut.sv | 16 +
 rtl/pc_branch_unit.sv | 116 +++++++++++
 tb/tb_pc_branch_unit.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/pc_branch_unit_pkg.sv
// rtl/pc_branch_unit_pkg.sv - shared types, widths, LUT contents and condition evaluation
// Purpose: definitions shared by the PC/branch unit and its optional target LUT.
//   cond_mne    : 3-bit branch condition code
//   run_state_t : run-control FSM states
//   flags_t     : registered ALU flags {z,p,o,c}
//   PC_LUT_ROM  : absolute branch targets used when PC_LUT_EN is defined
package pc_branch_unit_pkg;

  localparam int PC_W  = 10;
  localparam int OFF_W = 6;

  typedef enum logic [2:0] {
    COND_ALW = 3'd0,
    COND_EQ  = 3'd1,
    COND_NE  = 3'd2,
    COND_PAR = 3'd3,
    COND_ODD = 3'd4,
    COND_CS  = 3'd5,
    COND_CC  = 3'd6,
    COND_NEV = 3'd7
  } cond_mne;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } run_state_t;

  typedef struct packed {
    logic z;
    logic p;
    logic o;
    logic c;
  } flags_t;

  localparam logic [PC_W-1:0] PC_LUT_ROM [16] = '{
    10'd0,   10'd100, 10'd150, 10'd200,
    10'd250, 10'd300, 10'd350, 10'd400,
    10'd450, 10'd500, 10'd550, 10'd600,
    10'd650, 10'd700, 10'd750, 10'd1023
  };

  function automatic logic cond_eval(input cond_mne cond, input flags_t f);
    logic hit;
    hit = 1'b0;
    case (cond)
      COND_ALW: hit = 1'b1;
      COND_EQ:  hit = f.z;
      COND_NE:  hit = ~f.z;
      COND_PAR: hit = f.p;
      COND_ODD: hit = f.o;
      COND_CS:  hit = f.c;
      COND_CC:  hit = ~f.c;
      COND_NEV: hit = 1'b0;
      default:  hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/pc_branch_unit_lut.sv
// rtl/pc_branch_unit_lut.sv - 16-entry absolute branch target ROM (built only with PC_LUT_EN)
// Purpose: combinational lookup of an absolute PC from a 4-bit index.
//   idx  in  4     table index (Target[3:0])
//   addr out PC_W  absolute branch target
`ifdef PC_LUT_EN
module pc_lut
  import pc_branch_unit_pkg::*;
(
  input  logic [3:0]      idx,
  output logic [PC_W-1:0] addr
);

  assign addr = PC_LUT_ROM[idx];

endmodule
`endif

// File: rtl/pc_branch_unit.sv
// rtl/pc_branch_unit.sv - program counter, flag register, branch resolution and run control
// Purpose: latches ALU flags, resolves conditional branches against the registered
// flags and sequences IDLE/RUN/HALT with the test harness.
// Build option: PC_LUT_EN selects absolute LUT targets instead of signed relative offsets.
// Ports:
//   Clk, Reset                     clock, synchronous active-high reset
//   Start, Halt, Stall             run control and PC hold
//   FlagWr, ZeroIn..CarryIn        flag capture strobe and ALU flag inputs
//   BranchEn, BranchCond, Target   branch decode fields
//   ProgCtr                        current instruction address
//   Running, Done                  state decodes of RUN and HALT
//   Taken                          combinational branch-taken indication
module pc_branch_unit
  import pc_branch_unit_pkg::*;
#(
  parameter int PCW  = PC_W,
  parameter int OFFW = OFF_W
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic            Halt,
  input  logic            Stall,
  input  logic            FlagWr,
  input  logic            ZeroIn,
  input  logic            ParityIn,
  input  logic            OddIn,
  input  logic            CarryIn,
  input  logic            BranchEn,
  input  logic [2:0]      BranchCond,
  input  logic [OFFW-1:0] Target,
  output logic [PCW-1:0]  ProgCtr,
  output logic            Running,
  output logic            Done,
  output logic            Taken
);

  run_state_t       state, state_next;
  logic [PCW-1:0]   pc, pc_next;
  flags_t           flags, flags_next;
  logic [PCW-1:0]   target_pc;

`ifdef PC_LUT_EN
  logic [PC_W-1:0] lut_addr;
  logic            unused_target_hi;

  // Only the low nibble selects an entry; upper field bits carry no meaning here.
  assign unused_target_hi = ^Target[OFFW-1:4];

  pc_lut u_pc_lut (
    .idx  (Target[3:0]),
    .addr (lut_addr)
  );

  assign target_pc = PCW'(lut_addr);
`else
  // Relative branch: sign-extend the offset; the add wraps modulo 2^PCW.
  assign target_pc = pc + {{(PCW-OFFW){Target[OFFW-1]}}, Target};
`endif

  // Conditions read the registered flags, so a same-cycle FlagWr is not visible yet.
  assign Taken = BranchEn & (state == RUN) & cond_eval(cond_mne'(BranchCond), flags);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      pc    <= '0;
      flags <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      flags <= flags_next;
    end
  end

  always_comb begin
    state_next = state;
    pc_next    = pc;
    flags_next = flags;
    case (state)
      IDLE, HALT: begin
        if (Start) begin
          state_next = RUN;
          pc_next    = '0;
          flags_next = '0;
        end
      end
      RUN: begin
        if (FlagWr) begin
          flags_next = '{z: ZeroIn, p: ParityIn, o: OddIn, c: CarryIn};
        end
        // Halt and Stall both freeze the PC; a branch presented with either is dropped.
        if (Halt) begin
          state_next = HALT;
          pc_next    = pc;
        end else if (Stall) begin
          pc_next = pc;
        end else if (Taken) begin
          pc_next = target_pc;
        end else begin
          pc_next = pc + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        pc_next    = '0;
        flags_next = '0;
      end
    endcase
  end

  assign ProgCtr = pc;
  assign Running = (state == RUN);
  assign Done    = (state == HALT);

endmodule

// File: tb/tb_pc_branch_unit.sv
// tb/tb_pc_branch_unit.sv - directed self-checking bench for pc_branch_unit
module tb_pc_branch_unit;

  logic       Clk = 1'b0;
  logic       Reset, Start, Halt, Stall, FlagWr;
  logic       ZeroIn, ParityIn, OddIn, CarryIn;
  logic       BranchEn;
  logic [2:0] BranchCond;
  logic [5:0] Target;
  logic [9:0] ProgCtr;
  logic       Running, Done, Taken;

  int total = 0;
  int bad   = 0;

  always #5 Clk = ~Clk;

  pc_branch_unit dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Start      (Start),
    .Halt       (Halt),
    .Stall      (Stall),
    .FlagWr     (FlagWr),
    .ZeroIn     (ZeroIn),
    .ParityIn   (ParityIn),
    .OddIn      (OddIn),
    .CarryIn    (CarryIn),
    .BranchEn   (BranchEn),
    .BranchCond (BranchCond),
    .Target     (Target),
    .ProgCtr    (ProgCtr),
    .Running    (Running),
    .Done       (Done),
    .Taken      (Taken)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

`ifdef PC_LUT_EN
  localparam logic [9:0] EXP_BR5  = 10'd300;
  localparam logic [9:0] EXP_AFT  = 10'd301;
`else
  localparam logic [9:0] EXP_BR5  = 10'd17;
  localparam logic [9:0] EXP_AFT  = 10'd18;
`endif

  initial begin
    Reset = 1'b1; Start = 1'b0; Halt = 1'b0; Stall = 1'b0; FlagWr = 1'b0;
    ZeroIn = 1'b0; ParityIn = 1'b0; OddIn = 1'b0; CarryIn = 1'b0;
    BranchEn = 1'b0; BranchCond = 3'd0; Target = 6'd0;
    tick(); tick();
    Reset = 1'b0;
    BranchEn = 1'b1;
    #1;
    check("rst_pc", ProgCtr, 0);
    check("rst_running", Running, 0);
    check("rst_done", Done, 0);
    check("idle_taken", Taken, 0);
    BranchEn = 1'b0;

    // start and count
    Start = 1'b1; tick(); Start = 1'b0;
    check("start_running", Running, 1);
    check("start_pc", ProgCtr, 0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("count_pc", ProgCtr, i);
    end
    Halt = 1'b1; tick(); Halt = 1'b0;
    check("halt_done", Done, 1);
    check("halt_running", Running, 0);
    check("halt_pc", ProgCtr, 5);
    tick();
    check("halt_pc_hold", ProgCtr, 5);
    Start = 1'b1; tick(); Start = 1'b0;
    check("restart_pc", ProgCtr, 0);
    check("restart_running", Running, 1);
    check("restart_done", Done, 0);

    // stall with ignored start pulses
    for (int i = 0; i < 10; i++) tick();
    check("pre_stall_pc", ProgCtr, 10);
    Stall = 1'b1; Start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_pc", ProgCtr, 10);
    end
    Stall = 1'b0;
    tick(); Start = 1'b0;
    check("start_ignored_pc", ProgCtr, 11);
    check("start_ignored_run", Running, 1);

    // branch sees old flags in the FlagWr cycle, new ones afterwards
    FlagWr = 1'b1; ZeroIn = 1'b1; BranchEn = 1'b1; BranchCond = 3'd1; Target = 6'd5;
    #1;
    check("eq_old_flags_taken", Taken, 0);
    tick();
    check("eq_old_flags_pc", ProgCtr, 12);
    FlagWr = 1'b0; ZeroIn = 1'b0;
    #1;
    check("eq_new_flags_taken", Taken, 1);
    tick();
    check("eq_branch_pc", ProgCtr, EXP_BR5);
    BranchEn = 1'b0;

    // remaining conditions with P=1 O=0 C=1 Z=0
    FlagWr = 1'b1; ParityIn = 1'b1; CarryIn = 1'b1;
    tick();
    FlagWr = 1'b0; ParityIn = 1'b0; CarryIn = 1'b0;
    check("flagwr_pc", ProgCtr, EXP_AFT);
    BranchEn = 1'b1;
    BranchCond = 3'd3; #1; check("cond_par", Taken, 1);
    BranchCond = 3'd4; #1; check("cond_odd", Taken, 0);
    BranchCond = 3'd5; #1; check("cond_cs", Taken, 1);
    BranchCond = 3'd6; #1; check("cond_cc", Taken, 0);
    BranchCond = 3'd7; #1; check("cond_nev", Taken, 0);
    BranchCond = 3'd2; #1; check("cond_ne", Taken, 1);
    BranchCond = 3'd1; #1; check("cond_eq", Taken, 0);
    BranchCond = 3'd0; BranchEn = 1'b0; #1; check("no_branch_en", Taken, 0);

    // branch together with halt: halt wins
    BranchEn = 1'b1; BranchCond = 3'd0; Target = 6'd5; Halt = 1'b1;
    tick(); Halt = 1'b0;
    check("br_halt_pc", ProgCtr, EXP_AFT);
    check("br_halt_done", Done, 1);
    check("halt_state_taken", Taken, 0);
    BranchEn = 1'b0;

    // restart from HALT clears flags
    Start = 1'b1; tick(); Start = 1'b0;
    BranchEn = 1'b1;
    BranchCond = 3'd3; #1; check("restart_par_clear", Taken, 0);
    BranchCond = 3'd5; #1; check("restart_cs_clear", Taken, 0);
    BranchEn = 1'b0;

`ifdef PC_LUT_EN
    BranchEn = 1'b1; BranchCond = 3'd0; Target = 6'h33;
    tick(); BranchEn = 1'b0;
    check("lut_target_pc", ProgCtr, 200);
    tick();
    check("lut_next_pc", ProgCtr, 201);
`else
    tick(); tick();
    check("pre_wrap_pc", ProgCtr, 2);
    BranchEn = 1'b1; BranchCond = 3'd0; Target = 6'b111100;
    tick(); BranchEn = 1'b0;
    check("neg_wrap_pc", ProgCtr, 1022);
    tick();
    check("pc_1023", ProgCtr, 1023);
    tick();
    check("inc_wrap_pc", ProgCtr, 0);
`endif

    // reset mid-RUN at PC 37
    Halt = 1'b1; tick(); Halt = 1'b0;
    Start = 1'b1; tick(); Start = 1'b0;
    for (int i = 0; i < 37; i++) tick();
    check("pre_reset_pc", ProgCtr, 37);
    Reset = 1'b1; FlagWr = 1'b1; ZeroIn = 1'b1;
    tick();
    Reset = 1'b0; FlagWr = 1'b0; ZeroIn = 1'b0;
    check("mid_reset_pc", ProgCtr, 0);
    check("mid_reset_running", Running, 0);
    check("mid_reset_done", Done, 0);
    Start = 1'b1; tick(); Start = 1'b0;
    BranchEn = 1'b1; BranchCond = 3'd1; #1;
    check("mid_reset_flags", Taken, 0);
    BranchEn = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
